// File: rtl/mips_state_dump_if.sv
// mips_state_dump_if: read ports toward the register file / data memory and the dump output stream.
interface mips_state_dump_if #(
    parameter int MEM_AW = 5,
    parameter int DATA_W = 32
);
    logic [4:0]        rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic [MEM_AW-1:0] dm_raddr;
    logic [DATA_W-1:0] dm_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_tag;
    logic [7:0]        out_index;
    modport master (
        output rf_raddr, dm_raddr, out_valid, out_data, out_tag, out_index,
        input  rf_rdata, dm_rdata, out_ready
    );
    modport slave (
        input  rf_raddr, dm_raddr, out_valid, out_data, out_tag, out_index,
        output rf_rdata, dm_rdata, out_ready
    );
endinterface

// File: rtl/mips_state_dump.sv
// mips_state_dump: streams register file, then data memory, then a wrapping checksum
// over a valid/ready port.
module mips_state_dump #(
    parameter int N_REGS = 32,
    parameter int N_MEM  = 32,
    parameter int MEM_AW = 5,
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_busy,
    output logic o_done,
    mips_state_dump_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REGS  = 3'd1;
    localparam logic [2:0] S_MEM   = 3'd2;
    localparam logic [2:0] S_SUM   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [7:0] L_REG_LAST = 8'(N_REGS - 1);
    localparam logic [7:0] L_MEM_LAST = 8'(N_MEM - 1);

    logic [2:0]        r_state;
    logic [7:0]        r_idx;
    logic [DATA_W-1:0] r_sum;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_tag;
    logic [7:0]        r_index;
    logic              r_busy;
    logic              r_done;
    logic              w_free;
    logic              w_accept;
    logic              w_is_reg;
    logic [DATA_W-1:0] w_word;

    assign w_free   = !r_valid || bus.out_ready;
    assign w_accept = r_valid && bus.out_ready;
    assign w_is_reg = r_state == S_REGS;
    assign w_word   = w_is_reg ? bus.rf_rdata : bus.dm_rdata;

    assign bus.rf_raddr  = w_is_reg ? r_idx[4:0] : '0;
    assign bus.dm_raddr  = (r_state == S_MEM) ? r_idx[MEM_AW-1:0] : '0;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_tag   = r_tag;
    assign bus.out_index = r_index;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_sum   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_tag   <= 2'b00;
            r_index <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept)
                r_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_state <= S_REGS;
                    r_idx   <= '0;
                    r_sum   <= '0;
                    r_busy  <= 1'b1;
                end
                S_REGS, S_MEM: if (w_free) begin
                    r_valid <= 1'b1;
                    r_data  <= w_word;
                    r_tag   <= w_is_reg ? 2'b00 : 2'b01;
                    r_index <= r_idx;
                    r_sum   <= r_sum + w_word;
                    if (w_is_reg && r_idx == L_REG_LAST) begin
                        r_state <= S_MEM;
                        r_idx   <= '0;
                    end else if (!w_is_reg && r_idx == L_MEM_LAST) begin
                        r_state <= S_SUM;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 8'd1;
                    end
                end
                S_SUM: if (w_free) begin
                    r_valid <= 1'b1;
                    r_data  <= r_sum;
                    r_tag   <= 2'b10;
                    r_index <= '0;
                    r_state <= S_DRAIN;
                end
                // Linger in DRAIN through the done cycle so a start coinciding with done is ignored
                S_DRAIN: if (r_done) begin
                    r_state <= S_IDLE;
                end else if (w_accept) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/mips_state_dump.md
Name: mips_state_dump

Overview:
Post-run readout engine for the single-cycle MIPS core. On `start` it walks the register file, then data memory, through their asynchronous read ports and streams every word out over a valid/ready interface. It then emits a 32-bit checksum trailer. It sits beside the core so a host or checker can capture architectural state in silicon the way the bench dumps it in simulation.

Parameters:
N_REGS, 32, number of register-file entries dumped (indices 0..N_REGS-1)
N_MEM, 32, number of data-memory words dumped (word indices 0..N_MEM-1)
MEM_AW, 5, width of data-memory word-index address
DATA_W, 32, data width of both read ports and output stream

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset (see Behaviour)
start  in  1  one-cycle request to begin a dump; ignored unless state is IDLE
rf_raddr  out  5  register-file read address
rf_rdata  in  DATA_W  register-file read data, combinational from rf_raddr
dm_raddr  out  MEM_AW  data-memory word read address
dm_rdata  in  DATA_W  data-memory read data, combinational from dm_raddr
out_valid  out  1  out_data/out_tag/out_index hold a word
out_ready  in  1  consumer accepts word when out_valid && out_ready
out_data  out  DATA_W  dumped word or checksum
out_tag  out  2  00 register, 01 memory, 10 checksum, 11 unused
out_index  out  8  entry index within its region (0 for checksum)
busy  out  1  high from accepted start until done pulse
done  out  1  one-cycle pulse when the checksum word is accepted

Behaviour:
- Reset: one clock, synchronous, active-high on `rst`; outputs are registered unless stated otherwise.
  - On reset: state=IDLE, out_valid=0, out_data=0, out_tag=0, out_index=0, busy=0, done=0, internal index=0, checksum=0.
  - rf_raddr and dm_raddr are 0 in IDLE.
- Reset mid-dump aborts immediately to IDLE with the reset values above. The pending word is dropped and no done pulse is produced.
- States: IDLE -> REGS -> MEM -> SUM -> IDLE.
  - IDLE: start=1 -> REGS with index=0, checksum=0, busy=1 the next cycle.
- Load condition ("slot free") = !out_valid || out_ready.
- REGS:
  - rf_raddr = index[4:0], combinational from the index register.
  - On a slot-free cycle: out_data<=rf_rdata, out_tag<=00, out_index<=index, out_valid<=1, checksum<=checksum+rf_rdata (mod 2^32), index<=index+1.
  - Loading index N_REGS-1 moves to MEM with index=0.
- MEM: same as REGS but uses dm_raddr=index[MEM_AW-1:0] and out_tag=01. Loading index N_MEM-1 moves to SUM.
- SUM:
  - On a slot-free cycle: load out_data<=checksum, out_tag<=10, out_index<=0, out_valid<=1, then enter DRAIN (sub-phase of SUM).
  - When that word is accepted: out_valid<=0, busy<=0, done<=1 for exactly one cycle, state<=IDLE.
- Output rules:
  - out_valid/out_data/out_tag/out_index remain stable while out_valid && !out_ready.
  - Accept and reload in the same cycle is legal, giving full throughput of one word per cycle with out_ready held high.
  - Total words per dump = N_REGS + N_MEM + 1.
  - Latency: first word valid 2 cycles after the start cycle (start sampled -> REGS, then load).
- Checksum: wrapping 32-bit sum of all dumped words in stream order.
- start while busy has no effect; start in the same cycle as the done pulse is ignored (state still DRAIN).
- Read addresses change only on load cycles. The sampled word is whatever the read port returns that cycle. The core must be halted or stalled by the user; there is no coherence with concurrent writes.

Test Plan:
- Reg file preset r[i]=i*3, dmem[i]=0x1000+i, out_ready=1, pulse start → 65 consecutive words:
  - tags 00 ×32, then 01 ×32, then 10;
  - first out_valid 2 cycles after start;
  - checksum = 1488 + 0x20000 + 496 = 0x207C0;
  - done pulses 1 cycle after the checksum is accepted.
- Backpressure: out_ready toggles 1,0,0,1 repeating → every word is held stable while stalled; no word is lost or duplicated; out_index is contiguous 0..31 per region.
- rst=1 asserted at the 10th memory word → next cycle out_valid=0, busy=0, no done. A new start gives a complete stream beginning at register 0 with a correct checksum.
- start pulsed repeatedly while busy and in the done cycle → exactly one stream of 65 words; busy low after done.
- Checksum wrap: all entries 0xFFFFFFFF → checksum = 64 × 0xFFFFFFFF mod 2^32 = 0xFFFFFFC0.
- out_ready held 0 from start → exactly one word (reg 0) is presented and held, rf_raddr stays at 1, and the state does not advance.
